// File: rtl/pattern_detect_moore.sv
// ---------------------------------------------------------------------------
// pattern_detect_moore
//   Moore FSM that watches a qualified serial bit stream for the pattern
//   1-0-1-1-0 (first bit first). Overlapping matches are allowed: after a
//   match, the trailing "101" of the stream is reused as the start of the
//   next candidate.
//
//   Bits are only consumed when valid_i=1. When valid_i=0 the FSM holds its
//   state and data_i is ignored.
//
//   pattern_o is registered and reflects state==DETECT.
//
//   Optional feature (macro PATTERN_DETECT_COUNT_EN):
//     Adds match_cnt_o, a 16-bit saturating count of entries into DETECT
//     since the last reset. Without the macro the port and its logic are
//     absent.
//
//   Reset: rst_i is synchronous and active-high. It has priority over every
//   transition.
// ---------------------------------------------------------------------------
module pattern_detect_moore (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_i,
    input  logic        valid_i,
    output logic        pattern_o
`ifdef PATTERN_DETECT_COUNT_EN
    ,
    output logic [15:0] match_cnt_o
`endif
);

    // Each state is named after the longest suffix of the accepted bits that
    // is also a prefix of 10110.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_S1     = 3'd1,
        ST_S10    = 3'd2,
        ST_S101   = 3'd3,
        ST_S1011  = 3'd4,
        ST_DETECT = 3'd5
    } state_t;

    state_t state_r;
    state_t next_state_s;
    logic   pattern_r;

    // Next-state decode. Unreachable encodings fall back to IDLE, so a
    // corrupted state register recovers on the next valid bit.
    always_comb begin
        next_state_s = state_r;
        if (valid_i) begin
            case (state_r)
                ST_IDLE:   next_state_s = data_i ? ST_S1    : ST_IDLE;
                ST_S1:     next_state_s = data_i ? ST_S1    : ST_S10;
                ST_S10:    next_state_s = data_i ? ST_S101  : ST_IDLE;
                ST_S101:   next_state_s = data_i ? ST_S1011 : ST_S10;
                ST_S1011:  next_state_s = data_i ? ST_S1    : ST_DETECT;
                ST_DETECT: next_state_s = data_i ? ST_S101  : ST_IDLE;
                default:   next_state_s = ST_IDLE;
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // State register and registered DETECT flag, with reset taking priority.
    // pattern_r is loaded from the next state so that it always equals
    // (state_r == ST_DETECT) without an extra cycle of latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            pattern_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            pattern_r <= (next_state_s == ST_DETECT);
        end
    end

    assign pattern_o = pattern_r;

`ifdef PATTERN_DETECT_COUNT_EN
    logic [15:0] match_cnt_r;
    logic        enter_detect_s;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = 16'hFFFF;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    // A DETECT entry is a move into DETECT from any other state. Holding in
    // DETECT while valid_i=0 is not a new entry.
    always_comb begin
        enter_detect_s = 1'b0;
        if ((next_state_s == ST_DETECT) && (state_r != ST_DETECT)) begin
            enter_detect_s = 1'b1;
        end else begin
            enter_detect_s = 1'b0;
        end
    end

    // Saturating count of DETECT entries, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            match_cnt_r <= 16'd0;
        end else if (enter_detect_s) begin
            match_cnt_r <= sat_inc16(match_cnt_r);
        end else begin
            match_cnt_r <= match_cnt_r;
        end
    end

    assign match_cnt_o = match_cnt_r;
`endif

endmodule

// File: tb/tb_pattern_detect_moore.sv
// ---------------------------------------------------------------------------
// tb_pattern_detect_moore
//   Self-checking bench for pattern_detect_moore. The reference model keeps
//   the last five accepted bits since reset and flags a match when they read
//   10110. A negedge process compares the DUT against the model on every
//   cycle after the first reset. Directed scenarios also pin literal values.
//   A randomized phase follows the directed scenarios.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pattern_detect_moore;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        data_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        pattern_o;
`ifdef PATTERN_DETECT_COUNT_EN
    logic [15:0] match_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit          check_en = 1'b0;
    int          hist_len = 0;
    logic [4:0]  hist = 5'd0;
    logic        mdl_pattern = 1'b0;
    int          mdl_cnt = 0;

    pattern_detect_moore dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .pattern_o (pattern_o)
`ifdef PATTERN_DETECT_COUNT_EN
        ,
        .match_cnt_o (match_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input logic r, input logic v, input logic d);
        if (r) begin
            hist_len    = 0;
            hist        = 5'd0;
            mdl_pattern = 1'b0;
            mdl_cnt     = 0;
            check_en    = 1'b1;
        end else if (v) begin
            hist = {hist[3:0], d};
            if (hist_len < 5) hist_len++;
            mdl_pattern = (hist_len >= 5) && (hist == 5'b10110);
            if (mdl_pattern && mdl_cnt < 65535) mdl_cnt++;
        end
    endtask

    // Drive the inputs for one cycle, step the model at the edge, and settle.
    task automatic cyc(input logic r, input logic v, input logic d);
        rst_i   = r;
        valid_i = v;
        data_i  = d;
        @(posedge clk_i);
        model_step(r, v, d);
        #1;
    endtask

    // Check the DUT and the model against a hand-computed value.
    task automatic expect_lit(input string name, input logic exp);
        checks++;
        if (pattern_o !== exp || mdl_pattern !== exp) begin
            errors++;
            $display("FAIL %s: pattern_o=%b model=%b required=%b at %0t",
                     name, pattern_o, mdl_pattern, exp, $time);
        end
    endtask

    // Feed n valid bits (MSB first) and check the expected output after each.
    task automatic run_bits(input string name, input int n,
                            input logic [15:0] seq, input logic [15:0] ex);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, seq[n-1-i]);
            expect_lit(name, ex[n-1-i]);
        end
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        expect_lit("reset", 1'b0);
    endtask

    // Compare the DUT against the model on every cycle after the first reset.
    always @(negedge clk_i) begin
        if (check_en) begin
            checks++;
            if (pattern_o !== mdl_pattern) begin
                errors++;
                $display("FAIL model_pattern: pattern_o=%b required=%b at %0t",
                         pattern_o, mdl_pattern, $time);
            end
`ifdef PATTERN_DETECT_COUNT_EN
            checks++;
            if (match_cnt_o !== 16'(mdl_cnt)) begin
                errors++;
                $display("FAIL model_count: match_cnt_o=%0d required=%0d at %0t",
                         match_cnt_o, mdl_cnt, $time);
            end
`endif
        end
    end

    initial begin
        // Reset with valid high and data toggling still yields IDLE.
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        expect_lit("reset_state", 1'b0);

        // Basic match.
        run_bits("basic", 5, 16'b10110, 16'b00001);

        // Overlapping matches.
        do_reset();
        run_bits("overlap", 8, 16'b10110110, 16'b00000001 | 16'b00001000);
`ifdef PATTERN_DETECT_COUNT_EN
        checks++;
        if (match_cnt_o !== 16'd2) begin
            errors++;
            $display("FAIL overlap_count: match_cnt_o=%0d required=2", match_cnt_o);
        end
`endif

        // Valid gating between bits 3 and 4, with data toggling.
        do_reset();
        run_bits("gating_head", 3, 16'b101, 16'b000);
        cyc(1'b0, 1'b0, 1'b1); expect_lit("gating_hold", 1'b0);
        cyc(1'b0, 1'b0, 1'b0); expect_lit("gating_hold", 1'b0);
        cyc(1'b0, 1'b0, 1'b1); expect_lit("gating_hold", 1'b0);
        run_bits("gating_tail", 2, 16'b10, 16'b01);

        // Near miss through the S101 -> S10 path.
        do_reset();
        run_bits("near_miss", 7, 16'b1010110, 16'b0000001);

        // Reset mid-pattern; the final 0 arrives together with reset.
        do_reset();
        run_bits("mid_reset_head", 4, 16'b1011, 16'b0000);
        cyc(1'b1, 1'b1, 1'b0);
        expect_lit("mid_reset", 1'b0);
        run_bits("after_reset", 5, 16'b10110, 16'b00001);

        // Hold in DETECT while valid is low, then leave on a valid 0.
        cyc(1'b0, 1'b0, 1'b1); expect_lit("detect_hold1", 1'b1);
        cyc(1'b0, 1'b0, 1'b0); expect_lit("detect_hold2", 1'b1);
        cyc(1'b0, 1'b1, 1'b0); expect_lit("detect_exit", 1'b0);

        // Randomized phase checked by the negedge compare process.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)));
        end

        @(negedge clk_i);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_detect_moore.md
PATTERN_DETECT_MOORE -- requirements
Module: pattern_detect_moore

Interface
REQ-001 SHALL have a single clock and a reset that is synchronous and active-high; the ports are clk_i and rst_i.
REQ-002 SHALL provide port: clk_i  input  1  rising-edge clock.
REQ-003 SHALL provide port: rst_i  input  1  synchronous active-high reset.
REQ-004 SHALL provide port: data_i  input  1  serial data bit, sampled only when valid_i=1.
REQ-005 SHALL provide port: valid_i  input  1  qualifies data_i for the current cycle.
REQ-006 SHALL provide port: pattern_o  output  1  high while the FSM is in the DETECT state.
REQ-007 SHALL provide port, only when PATTERN_DETECT_COUNT_EN is defined: match_cnt_o  output  16  number of DETECT-state entries since reset.

Function
REQ-008 SHALL detect the fixed serial pattern 1-0-1-1-0, first bit first, with overlapping matches allowed.
REQ-009 SHALL implement a Moore FSM with six states: IDLE, S1 ("1"), S10, S101, S1011, DETECT ("10110").
REQ-010 SHALL use these transitions on valid_i=1, written as data 0 / data 1: IDLE -> IDLE / S1.
REQ-011 SHALL transition S1 -> S10 / S1.
REQ-012 SHALL transition S10 -> IDLE / S101.
REQ-013 SHALL transition S101 -> S10 / S1011.
REQ-014 SHALL transition S1011 -> DETECT / S1.
REQ-015 SHALL transition DETECT -> IDLE / S101, so that the overlap suffix "101" is reused.
REQ-016 SHALL hold the current state when valid_i=0, and SHALL ignore data_i in that cycle.
REQ-017 SHALL register pattern_o and drive it as a pure function of state: pattern_o=1 iff state==DETECT.
REQ-018 SHALL raise pattern_o in the cycle after the clock edge that samples the final 0 of the pattern (one-cycle latency).
REQ-019 SHALL keep pattern_o high for exactly one cycle when the next cycle has valid_i=1; it stays high while valid_i=0 holds DETECT.
REQ-020 SHALL keep pattern_o low in every non-DETECT state.
REQ-021 SHALL produce no X on any output after reset, whatever the data_i value when valid_i=0.

Reset
REQ-022 SHALL, while rst_i=1 at a rising clk_i, set state=IDLE and pattern_o=0 (and match_cnt_o=0 when enabled), regardless of valid_i and data_i.
REQ-023 SHALL let reset asserted mid-pattern discard the partial match; detection restarts from IDLE on the first valid bit after rst_i falls.
REQ-024 SHALL give reset priority over any state transition in the same cycle.

Configuration
REQ-025 SHALL, with macro PATTERN_DETECT_COUNT_EN defined, add match_cnt_o, incremented by 1 on each transition into DETECT, saturating at 16'hFFFF.
REQ-026 SHALL, without PATTERN_DETECT_COUNT_EN, omit match_cnt_o and its logic; all other behaviour is identical.

Verification
REQ-027 SHALL cover basic match: after reset, valid_i=1 with bits 1,0,1,1,0 -> pattern_o=0 for the first four bits, and =1 in the cycle after the fifth bit is sampled.
REQ-028 SHALL cover overlap: bits 1,0,1,1,0,1,1,0 all valid -> pattern_o pulses twice, after bit 5 and after bit 8; match_cnt_o=2 when enabled.
REQ-029 SHALL cover valid gating: pattern 1,0,1,1,0 with valid_i=0 for 3 cycles between bits 3 and 4 (data_i toggling) -> one detection, delayed by 3 cycles.
REQ-030 SHALL cover a near-miss: bits 1,0,1,0,1,1,0 -> a single pattern_o pulse after bit 7 (the S101 -> S10 path is exercised).
REQ-031 SHALL cover reset mid-pattern: bits 1,0,1,1, then rst_i=1 for 1 cycle, then 0 -> no pattern_o; a following 1,0,1,1,0 -> one pulse.
REQ-032 SHALL cover the hold in DETECT: after a match, valid_i=0 for 2 cycles -> pattern_o stays 1 for 3 cycles total, then a valid 0 -> pattern_o=0.
